gpio_bus_arbiter: RTL and testbench



---
 rtl/gpio_bus_arbiter_pkg.sv | 10 +
 rtl/gpio_bus_if.sv | 14 +
 rtl/gpio_bus_rr_pick.sv | 8 +
 rtl/gpio_bus_arbiter.sv | 85 ++++++++
 tb/tb_gpio_bus_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gpio_bus_arbiter_pkg.sv
// gpio_bus_arbiter_pkg: state encodings and constants shared by the gpio bus arbiter
package gpio_bus_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_GNT0 = 2'b01,
      ARB_GNT1 = 2'b10
   } arb_state_t;
   localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
   localparam int ARB_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/gpio_bus_if.sv
// gpio_bus_if: native memory bus (valid/addr/wdata/wstrb -> rdata/ready) between a master and a slave
interface gpio_bus_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  valid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  ready;
   modport master (output valid, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/gpio_bus_rr_pick.sv
// gpio_bus_rr_pick: two-way round-robin picker; on a tie the master that was not served last wins
module gpio_bus_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);
   assign pick = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-master round-robin arbiter in front of the gpio slave; ARB_TIMEOUT_EN adds a slave-ready watchdog
module gpio_bus_arbiter
   import gpio_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   gpio_bus_if.slave  m0,
   gpio_bus_if.slave  m1,
   gpio_bus_if.master s,
   output logic [1:0] grant,
   output logic       err
);
   arb_state_t state, state_nxt;
   logic       last, last_nxt;
   logic       own, sel1, own_valid, tmo;
   logic [1:0] pick;

   gpio_bus_rr_pick u_pick (
      .req  ({m1.valid, m0.valid}),
      .last (last),
      .pick (pick)
   );

   assign own       = state != ARB_IDLE;
   assign sel1      = state == ARB_GNT1;
   assign own_valid = own && (sel1 ? m1.valid : m0.valid);
   assign grant     = state;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   assign tmo = own_valid && !s.ready && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1);
   // watchdog counts stalled granted cycles and restarts whenever the grant is idle or the slave answers
   always_ff @(posedge clk) begin
      if (rst || !own || s.ready)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   // arbitration state and round-robin history; last=1 lets m0 win the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // next state, request mux towards the slave and response steering back to the owner only
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      s.valid   = own_valid && !tmo;
      s.addr    = !own ? ADDR_W'(0) : sel1 ? m1.addr : m0.addr;
      s.wdata   = !own ? DATA_W'(0) : sel1 ? m1.wdata : m0.wdata;
      s.wstrb   = !own ? (DATA_W/8)'(0) : sel1 ? m1.wstrb : m0.wstrb;
      m0.ready  = state == ARB_GNT0 && (s.ready || tmo);
      m1.ready  = sel1 && (s.ready || tmo);
      m0.rdata  = state != ARB_GNT0 ? DATA_W'(0) : tmo ? DATA_W'(ARB_TIMEOUT_RDATA) : s.rdata;
      m1.rdata  = !sel1 ? DATA_W'(0) : tmo ? DATA_W'(ARB_TIMEOUT_RDATA) : s.rdata;
      err       = tmo;
      if (!own)
         state_nxt = pick[0] ? ARB_GNT0 : (pick[1] ? ARB_GNT1 : ARB_IDLE);
      else if (!own_valid)
         state_nxt = ARB_IDLE;
      else if (s.ready || tmo) begin
         state_nxt = ARB_IDLE;
         last_nxt  = sel1;
      end
   end
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed vector table plus hand-written sequences for the gpio bus arbiter
module tb_gpio_bus_arbiter;
   typedef struct {
      logic [3:0]  in;
      logic [4:0]  ex;
      logic [3:0]  sa;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  grant;
   logic        err;
   logic [31:0] mem [16] = '{3: 32'h33, default: 32'h0};
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        tv [20];

   gpio_bus_if m0_if ();
   gpio_bus_if m1_if ();
   gpio_bus_if s_if ();

   gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .grant (grant),
      .err   (err)
   );

   always #5 clk = ~clk;

   assign s_if.ready = s_if.valid & ~stall;
   assign s_if.rdata = mem[s_if.addr[3:0]];

   always @(posedge clk) begin
      if (s_if.valid && s_if.ready)
         for (int b = 0; b < 4; b++)
            if (s_if.wstrb[b]) mem[s_if.addr[3:0]][8*b +: 8] <= s_if.wdata[8*b +: 8];
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      int          c0, c1, cnt, errs;
      logic        done, seen0;
      logic [31:0] d;
      tv = '{
         '{4'b1000, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0100, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0100, 5'b01110, 4'h1, 32'h0,  32'h0},
         '{4'b0000, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0110, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0110, 5'b10101, 4'h2, 32'h0,  32'h0},
         '{4'b0100, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0111, 5'b01100, 4'h1, 32'hFF, 32'h0},
         '{4'b0111, 5'b01100, 4'h1, 32'hFF, 32'h0},
         '{4'b0011, 5'b01000, 4'h1, 32'hFF, 32'h0},
         '{4'b0110, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0110, 5'b01110, 4'h1, 32'hFF, 32'h0},
         '{4'b0011, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0011, 5'b10100, 4'h2, 32'h0,  32'hAA},
         '{4'b1111, 5'b10100, 4'h2, 32'h0,  32'hAA},
         '{4'b0110, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0110, 5'b01110, 4'h1, 32'hFF, 32'h0},
         '{4'b0010, 5'b00000, 4'h0, 32'h0,  32'h0},
         '{4'b0010, 5'b10101, 4'h2, 32'h0,  32'hAA},
         '{4'b0000, 5'b00000, 4'h0, 32'h0,  32'h0}
      };
      m0_if.valid = 1'b0; m0_if.addr = 32'h1; m0_if.wdata = 32'hFF; m0_if.wstrb = 4'hF;
      m1_if.valid = 1'b0; m1_if.addr = 32'h2; m1_if.wdata = 32'hAA; m1_if.wstrb = 4'hF;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         {rst, m0_if.valid, m1_if.valid, stall} = tv[i].in;
         #1;
         chk($sformatf("vec%0d", i),
             {grant, s_if.valid, m0_if.ready, m1_if.ready, s_if.addr[3:0], m0_if.rdata, m1_if.rdata},
             {tv[i].ex, tv[i].sa, tv[i].d0, tv[i].d1});
      end
      chk("ddrc_value", mem[1], 32'hFF);
      chk("portc_value", mem[2], 32'hAA);

      m0_if.wstrb = 4'h0;
      m1_if.wstrb = 4'h0;
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         m0_if.valid = 1'b1;
         m1_if.valid = 1'b1;
         #1;
         chk($sformatf("rr_grant%0d", i), grant, (i % 2 == 0) ? 2'b00 : ((i / 2) % 2 == 0 ? 2'b01 : 2'b10));
         if (m0_if.ready) begin
            c0++;
            chk("rr_m0_rdata", m0_if.rdata, 32'hFF);
         end
         if (m1_if.ready) begin
            c1++;
            chk("rr_m1_rdata", m1_if.rdata, 32'hAA);
         end
      end
      chk("rr_m0_count", c0, 4);
      chk("rr_m1_count", c1, 4);

      @(negedge clk);
      m0_if.valid = 1'b0;
      m1_if.valid = 1'b0;
      m1_if.addr  = 32'h3;
      done  = 1'b0;
      seen0 = 1'b0;
      d     = 32'h0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk);
         m1_if.valid = 1'b1;
         #1;
         if (m0_if.ready) seen0 = 1'b1;
         if (m1_if.ready) begin
            d    = m1_if.rdata;
            done = 1'b1;
         end
      end
      chk("pinc_done", done, 1'b1);
      chk("pinc_rdata", d, 32'h33);
      chk("pinc_m0_quiet", seen0, 1'b0);

      @(negedge clk);
      m1_if.valid = 1'b0;
      m0_if.addr  = 32'h1;
      stall       = 1'b1;
      cnt  = 0;
      errs = 0;
      done = 1'b0;
      d    = 32'h0;
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         m0_if.valid = 1'b1;
         #1;
         if (grant == 2'b01) cnt++;
         if (err) errs++;
         if (m0_if.ready) begin
            d    = m0_if.rdata;
            done = 1'b1;
            chk("wd_s_valid_low", s_if.valid, 1'b0);
         end
      end
      chk("wd_done", done, 1'b1);
      chk("wd_cycles", cnt, 16);
      chk("wd_rdata", d, gpio_bus_arbiter_pkg::ARB_TIMEOUT_RDATA);
      chk("wd_err_pulses", errs, 1);
      @(negedge clk);
      m0_if.valid = 1'b0;
      #1;
      chk("wd_idle", grant, 2'b00);
`else
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         m0_if.valid = 1'b1;
         #1;
         if (m0_if.ready) done = 1'b1;
         if (err) errs++;
      end
      chk("hold_grant", grant, 2'b01);
      chk("hold_no_ready", done, 1'b0);
      chk("hold_no_err", errs, 0);
`endif
      @(negedge clk);
      m0_if.valid = 1'b0;
      stall       = 1'b0;
      #1;
      chk("final_s_valid", s_if.valid, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
